// File: rtl/param_register_file.sv
// ---------------------------------------------------------------------------
// param_register_file
//
// Purpose:
//   ID-stage register file for the pipelined CPU. DEPTH = 2**ADDR_W entries
//   of DATA_W bits, one write port (driven from WB) and NUM_RD independent
//   registered read ports. Each entry also carries a busy bit. The busy bit
//   is set when a producer issues (reserve) and cleared when that producer
//   writes back. The ID stage uses it to detect hazards and stall.
//   Optionally, register 0 is hardwired to zero.
//
// Configuration:
//   REGFILE_BYPASS_EN (macro)
//     defined   : a read that lands in the same cycle as a write to the
//                 same index returns writeData, plus the busy bit as it is
//                 updated in that cycle (write-before-read).
//     undefined : a read returns the storage contents and busy bit as they
//                 were before that cycle's update (read-before-write).
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   register index width, DEPTH = 2**ADDR_W
//   NUM_RD   number of read ports (>= 1)
//   ZERO_REG 1: register 0 reads as 0 and ignores writes and reserves
//
// Ports:
//   CLK        in   clock, all state updates on posedge
//   RST        in   synchronous reset, active-high
//   RegWrite   in   write enable
//   writeReg   in   write index
//   writeData  in   write data
//   reserveEn  in   mark reserveReg busy
//   reserveReg in   index to mark busy
//   readEn     in   per-port read request
//   readReg    in   port k index at [k*ADDR_W +: ADDR_W]
//   readData   out  port k data at [k*DATA_W +: DATA_W]
//   readValid  out  port k data valid this cycle
//   readBusy   out  port k addressed register has a pending write
// ---------------------------------------------------------------------------
module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        writeReg,
    input  logic [DATA_W-1:0]        writeData,
    input  logic                     reserveEn,
    input  logic [ADDR_W-1:0]        reserveReg,
    input  logic [NUM_RD-1:0]        readEn,
    input  logic [NUM_RD*ADDR_W-1:0] readReg,
    output logic [NUM_RD*DATA_W-1:0] readData,
    output logic [NUM_RD-1:0]        readValid,
    output logic [NUM_RD-1:0]        readBusy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic              writeHit;
    logic              reserveHit;

    // Writes and reserves aimed at a hardwired zero register are dropped
    // entirely, so register 0 never stores data and never goes busy.
    assign writeHit   = RegWrite  && !((ZERO_REG != 0) && (writeReg   == '0));
    assign reserveHit = reserveEn && !((ZERO_REG != 0) && (reserveReg == '0));

    // The reserve is applied after the write-back clear. If a new producer
    // issues to the same register that an older producer is writing back,
    // the register stays busy.
    always_comb begin
        busyNext = busy;
        if (writeHit) begin
            busyNext[writeReg] = 1'b0;
        end
        if (reserveHit) begin
            busyNext[reserveReg] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (writeHit) begin
                regs[writeReg] <= writeData;
            end
            busy <= busyNext;
        end
    end

    // Read ports: each one is fully independent and registers its own result.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : gRead
        logic [ADDR_W-1:0] idx;
        logic              isZero;
        logic [DATA_W-1:0] srcData;
        logic              srcBusy;
        logic [DATA_W-1:0] dataQ;
        logic              validQ;
        logic              busyQ;

        assign idx    = readReg[gi*ADDR_W +: ADDR_W];
        assign isZero = (ZERO_REG != 0) && (idx == '0);

        always_comb begin
`ifdef REGFILE_BYPASS_EN
            if (writeHit && (writeReg == idx)) begin
                // Write-before-read: the result reflects this cycle's write,
                // including a same-cycle reserve that re-marks the register busy.
                srcData = writeData;
                srcBusy = busyNext[idx];
            end else begin
                srcData = regs[idx];
                srcBusy = busy[idx];
            end
`else
            srcData = regs[idx];
            srcBusy = busy[idx];
`endif
            if (isZero) begin
                srcData = '0;
                srcBusy = 1'b0;
            end
        end

        // While readEn is low, the data and busy outputs keep their last
        // values. Only the valid flag drops.
        always_ff @(posedge CLK) begin
            if (RST) begin
                dataQ  <= '0;
                validQ <= 1'b0;
                busyQ  <= 1'b0;
            end else begin
                validQ <= readEn[gi];
                if (readEn[gi]) begin
                    dataQ <= srcData;
                    busyQ <= srcBusy;
                end
            end
        end

        assign readData[gi*DATA_W +: DATA_W] = dataQ;
        assign readValid[gi]                 = validQ;
        assign readBusy[gi]                  = busyQ;
    end

endmodule
